// File: rtl/dcp_tx_fmt.sv
// ---------------------------------------------------------------------------
// dcp_tx_fmt
//
// Transmit-side formatter and 8N1 UART serializer for the debug command
// processors. A command block raises req_tx with either one ASCII character
// (type_tx = 0, din[7:0]) or a 32-bit word (type_tx = 1). A word is printed
// as 8 uppercase hex digits, most significant nibble first. Every character
// is sent as an 8N1 frame on txd. Characters follow each other with no idle
// gap. ack_tx pulses once after the last stop bit completes.
//
// Optional feature macro: DCP_TX_TRAILSP_EN
//   When defined, a word transfer appends an ASCII space (8'h20) after the
//   eight hex digits. Character transfers are unaffected.
//
// Parameters:
//   CLK_DIV  clock cycles per UART bit (>= 2), default 868 (100 MHz/115200)
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active high
//   req_tx   request level from the command block, held until ack_tx
//   type_tx  0 = single character, 1 = 32-bit word as hex
//   din      character or word, sampled only when the request is accepted
//   ack_tx   one-cycle completion pulse (registered)
//   busy     high from the cycle after accept through the HOLD cycle
//   txd      UART serial line, idle high (registered)
// ---------------------------------------------------------------------------
module dcp_tx_fmt #(
    parameter int CLK_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [31:0] din,
    output logic        ack_tx,
    output logic        busy,
    output logic        txd
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

`ifdef DCP_TX_TRAILSP_EN
    localparam logic [3:0] HEX_NCHAR = 4'd9;
`else
    localparam logic [3:0] HEX_NCHAR = 4'd8;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BITS,
        S_STOP,
        S_ACK,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic        type_q, type_d;
    logic [3:0]  nchar_q, nchar_d;
    logic [3:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        txd_q, txd_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;

    logic [3:0]  cur_nib;
    logic [7:0]  cur_char;

    // Map a nibble to its uppercase hex ASCII digit ('0'..'9', 'A'..'F').
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Character selection for the LOAD cycle. Word transfers walk the nibbles
    // from the most significant end; index 8 only exists when the trailing
    // space is enabled.
    always_comb begin
        cur_nib  = 4'h0;
        cur_char = 8'h00;
        case (idx_q[2:0])
            3'd0: cur_nib = word_q[31:28];
            3'd1: cur_nib = word_q[27:24];
            3'd2: cur_nib = word_q[23:20];
            3'd3: cur_nib = word_q[19:16];
            3'd4: cur_nib = word_q[15:12];
            3'd5: cur_nib = word_q[11:8];
            3'd6: cur_nib = word_q[7:4];
            default: cur_nib = word_q[3:0];
        endcase
        if (!type_q) begin
            cur_char = word_q[7:0];
        end else begin
`ifdef DCP_TX_TRAILSP_EN
            if (idx_q[3])
                cur_char = 8'h20;
            else
                cur_char = hex_ascii(cur_nib);
`else
            cur_char = hex_ascii(cur_nib);
`endif
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that they can be registered: the value assigned to txd_d on a
    // transition is the line level for the first cycle of the new state.
    // The LOAD cycle already drives the start bit and counts as its first
    // bit-time cycle, so a frame is exactly 10*CLK_DIV cycles.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        type_d  = type_q;
        nchar_d = nchar_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        ack_d   = ack_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (req_tx) begin
                    word_d  = din;
                    type_d  = type_tx;
                    nchar_d = type_tx ? HEX_NCHAR : 4'd1;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                sh_d    = cur_char;
                cnt_d   = CW'(1);
                state_d = S_START;
            end

            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    txd_d   = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    state_d = S_BITS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_BITS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (({1'b0, idx_q} + 5'd1) < {1'b0, nchar_q}) begin
                        idx_d   = idx_q + 4'd1;
                        txd_d   = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        txd_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_ACK: begin
                ack_d   = 1'b0;
                state_d = S_HOLD;
            end

            // The requester drops req_tx one cycle after seeing ack_tx, so
            // this cycle must not look at it.
            S_HOLD: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                txd_d   = 1'b1;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any partial frame and
    // returns the line to idle without issuing an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            type_q  <= 1'b0;
            nchar_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            type_q  <= type_d;
            nchar_q <= nchar_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign txd    = txd_q;
    assign ack_tx = ack_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// ---------------------------------------------------------------------------
// tb_dcp_tx_fmt
//
// Testbench for dcp_tx_fmt with CLK_DIV = 4. Expected line levels come from
// a frame-level model: the list of characters a request should produce, and
// for any cycle after accept, which frame/bit slot that cycle falls into.
// Honours DCP_TX_TRAILSP_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_dcp_tx_fmt;

    localparam int D = 4;
`ifdef DCP_TX_TRAILSP_EN
    localparam int NH = 9;
`else
    localparam int NH = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_tx;
    logic        type_tx;
    logic [31:0] din;
    logic        ack_tx;
    logic        busy;
    logic        txd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_bytes [0:8];
    int         exp_n;
    logic [7:0] obs_bytes [0:8];
    int         obs_ack;

    typedef struct {
        logic        typ;
        logic [31:0] word;
        bit          chaos;
        logic [7:0]  first_ch;
        logic [7:0]  last_ch;
        int          ack_cyc;
    } vec_t;

    vec_t tbl [6];

    dcp_tx_fmt #(.CLK_DIV(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_tx  (req_tx),
        .type_tx (type_tx),
        .din     (din),
        .ack_tx  (ack_tx),
        .busy    (busy),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Last character of a word transfer: the trailing space if enabled.
    function automatic logic [7:0] tail_ch(input logic [7:0] last_hex);
`ifdef DCP_TX_TRAILSP_EN
        return 8'h20;
`else
        return last_hex;
`endif
    endfunction

    // Characters a request should put on the line.
    function automatic void build_model(input logic typ, input logic [31:0] word);
        for (int i = 0; i < 9; i++) exp_bytes[i] = 8'h00;
        if (!typ) begin
            exp_bytes[0] = word[7:0];
            exp_n = 1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                int n;
                n = int'((word >> (28 - 4 * i)) & 32'hF);
                exp_bytes[i] = (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
            end
            exp_n = NH;
`ifdef DCP_TX_TRAILSP_EN
            exp_bytes[8] = 8'h20;
`endif
        end
    endfunction

    // Line level in cycle A+k (k >= 1, before the ack cycle).
    function automatic logic model_txd(input int k);
        int f, slot;
        f    = (k - 1) / (10 * D);
        slot = ((k - 1) % (10 * D)) / D;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return exp_bytes[f][slot - 1];
    endfunction

    // Runs one transfer. Must be entered just after a rising edge of a cycle
    // in which the DUT is idle; that cycle is cycle A. Returns at the falling
    // edge of the HOLD cycle when keep_req is set (req_tx left high), else at
    // the falling edge of the following idle cycle.
    task automatic apply_stimulus(input logic typ, input logic [31:0] word,
                                  input bit keep_req, input bit chaos);
        int last;
        req_tx  = 1'b1;
        type_tx = typ;
        din     = word;
        build_model(typ, word);
        last    = 10 * exp_n * D + 1;
        obs_ack = -1;
        for (int i = 0; i < 9; i++) obs_bytes[i] = 8'h00;
        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk);
            #1;
            if (chaos && k < last) begin
                din     = $urandom;
                type_tx = 1'($urandom_range(0, 1));
                req_tx  = 1'($urandom_range(0, 1));
            end
            if (k == last + 1 && !keep_req) req_tx = 1'b0;
            @(negedge clk);
            if (k < last) begin
                check_output($sformatf("txd@A+%0d", k), {31'd0, txd}, {31'd0, model_txd(k)});
                check_output($sformatf("ack_tx@A+%0d", k), {31'd0, ack_tx}, 32'd0);
                if (((k - 1) % D) == D / 2) begin
                    int f, slot;
                    f    = (k - 1) / (10 * D);
                    slot = ((k - 1) % (10 * D)) / D;
                    if (slot >= 1 && slot <= 8) obs_bytes[f][slot - 1] = txd;
                end
            end else begin
                check_output($sformatf("txd@A+%0d", k), {31'd0, txd}, 32'd1);
                check_output($sformatf("ack_tx@A+%0d", k), {31'd0, ack_tx},
                             (k == last) ? 32'd1 : 32'd0);
            end
            check_output($sformatf("busy@A+%0d", k), {31'd0, busy}, 32'd1);
            if (ack_tx === 1'b1 && obs_ack < 0) obs_ack = k;
        end
        if (!keep_req) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_output("busy_after_hold", {31'd0, busy}, 32'd0);
            check_output("txd_after_hold", {31'd0, txd}, 32'd1);
            check_output("ack_after_hold", {31'd0, ack_tx}, 32'd0);
        end
    endtask

    initial begin
        int acks_seen, lows_seen;

        tbl[0] = '{1'b0, 32'h0000_0052, 1'b0, 8'h52, 8'h52, 10 * D + 1};
        tbl[1] = '{1'b1, 32'h1234_ABCD, 1'b0, 8'h31, tail_ch(8'h44), 10 * NH * D + 1};
        tbl[2] = '{1'b1, 32'h0000_000F, 1'b1, 8'h30, tail_ch(8'h46), 10 * NH * D + 1};
        tbl[3] = '{1'b0, 32'hFFFF_FF00, 1'b0, 8'h00, 8'h00, 10 * D + 1};
        tbl[4] = '{1'b0, 32'h0000_00FF, 1'b1, 8'hFF, 8'hFF, 10 * D + 1};
        tbl[5] = '{1'b1, 32'hFEDC_BA90, 1'b0, 8'h46, tail_ch(8'h30), 10 * NH * D + 1};

        rst     = 1'b1;
        req_tx  = 1'b0;
        type_tx = 1'b0;
        din     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_txd", {31'd0, txd}, 32'd1);
        check_output("reset_ack", {31'd0, ack_tx}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);

        // Table-driven transfers
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            apply_stimulus(tbl[t].typ, tbl[t].word, 1'b0, tbl[t].chaos);
            check_output($sformatf("vec%0d_first_char", t), {24'd0, obs_bytes[0]},
                         {24'd0, tbl[t].first_ch});
            check_output($sformatf("vec%0d_last_char", t),
                         {24'd0, obs_bytes[tbl[t].typ ? NH - 1 : 0]}, {24'd0, tbl[t].last_ch});
            check_output($sformatf("vec%0d_ack_cycle", t), obs_ack, tbl[t].ack_cyc);
        end

        // Requester keeps req_tx high through HOLD, then new data is accepted
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 32'h0000_0041, 1'b1, 1'b0);
        check_output("keep_first_ack", obs_ack, 10 * D + 1);
        din     = 32'h0000_000D;
        type_tx = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 32'h0000_000D, 1'b0, 1'b0);
        check_output("keep_second_char", {24'd0, obs_bytes[0]}, 32'h0D);
        check_output("keep_second_ack", obs_ack, 10 * D + 1);

        // Reset during bit 3 of the second hex digit
        @(posedge clk);
        #1;
        req_tx  = 1'b1;
        type_tx = 1'b1;
        din     = 32'h1234_ABCD;
        build_model(1'b1, 32'h1234_ABCD);
        for (int k = 1; k <= 58; k++) begin
            @(posedge clk);
            #1;
            if (k == 58) rst = 1'b1;
            @(negedge clk);
            check_output($sformatf("pre_rst_txd@A+%0d", k), {31'd0, txd}, {31'd0, model_txd(k)});
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        req_tx = 1'b0;
        @(negedge clk);
        check_output("post_rst_txd", {31'd0, txd}, 32'd1);
        check_output("post_rst_busy", {31'd0, busy}, 32'd0);
        check_output("post_rst_ack", {31'd0, ack_tx}, 32'd0);
        acks_seen = 0;
        lows_seen = 0;
        for (int k = 0; k < 10 * NH * D + 20; k++) begin
            @(negedge clk);
            if (ack_tx === 1'b1) acks_seen++;
            if (txd !== 1'b1) lows_seen++;
        end
        check_output("post_rst_no_ack", acks_seen, 0);
        check_output("post_rst_line_idle", lows_seen, 0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 32'h0000_000A, 1'b0, 1'b0);
        check_output("after_rst_char", {24'd0, obs_bytes[0]}, 32'h0A);
        check_output("after_rst_ack", obs_ack, 10 * D + 1);

        // Randomized transfers against the frame-level model
        for (int r = 0; r < 6; r++) begin
            logic        rtyp;
            logic [31:0] rword;
            bit          rchaos;
            rtyp   = 1'($urandom_range(0, 1));
            rword  = $urandom;
            rchaos = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1;
            apply_stimulus(rtyp, rword, 1'b0, rchaos);
            check_output($sformatf("rand%0d_ack_cycle", r), obs_ack, 10 * exp_n * D + 1);
            for (int i = 0; i < exp_n; i++)
                check_output($sformatf("rand%0d_char%0d", r, i), {24'd0, obs_bytes[i]},
                             {24'd0, exp_bytes[i]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
